// File: rtl/imem_boot_loader.sv
// Boot loader: takes a word-count header then a byte stream, writes it big-endian
// from address 0 into instruction memory, and holds the core in reset until done.
module imem_boot_loader #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              core_resetn,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
  // rx_ready depends only on state, never on rx_valid.

  localparam int CNT_W = $clog2(MEM_BYTES + 1);
  localparam logic [9:0] MAX_BYTES = 10'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  remaining, remaining_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              accept;
  logic [9:0]        hdr_bytes;

  assign accept    = rx_valid && rx_ready;
  assign hdr_bytes = {rx_data, 2'b00};
  assign state_dbg = state;

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    addr_nxt      = addr;
    rx_ready      = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR;
      end
      S_HDR: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (rx_data == 8'd0) begin
            state_nxt = S_DONE;
          end else if (hdr_bytes > MAX_BYTES) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt     = S_LOAD;
            remaining_nxt = CNT_W'(hdr_bytes);
            addr_nxt      = '0;
          end
        end
      end
      S_LOAD: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          addr_nxt      = addr + ADDR_W'(1);
          remaining_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_HDR;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      remaining   <= '0;
      addr        <= '0;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      core_resetn <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      addr      <= addr_nxt;
      // Write port is registered: the write lands the cycle after the accept.
      mem_we    <= (state == S_LOAD) && accept;
      if ((state == S_LOAD) && accept) begin
        mem_waddr <= addr;
        mem_wdata <= rx_data;
      end
      // Released one cycle into DONE so the final write has retired first.
      core_resetn <= (state == S_DONE) && !start;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: control vector table, directed
// multi-cycle sequences and randomized images checked against an expected-write queue.
module tb_imem_boot_loader;

  localparam int MEM_BYTES = 64;
  localparam int ADDR_W    = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              core_resetn;
  logic              busy;
  logic              done;
  logic              error;
  logic [2:0]        state_dbg;

  int tests = 0;
  int fails = 0;
  logic drv_is_data = 1'b0;
  logic pend = 1'b0;
  logic [ADDR_W+7:0] exp_q[$];
  logic [7:0] basic_img [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h93};

  imem_boot_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .core_resetn(core_resetn),
    .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every data byte accepted must appear as exactly one write the next cycle.
  always @(negedge clk) begin
    logic [ADDR_W+7:0] e;
    chk("mem_we_timing", {63'd0, mem_we}, {63'd0, pend});
    if (pend && mem_we) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr_data", 64'({mem_waddr, mem_wdata}), 64'(e));
      end
    end
    chk("status_onehot", 64'(int'(busy) + int'(done) + int'(error) > 1), 64'd0);
    if (core_resetn) chk("core_resetn_only_in_done", {63'd0, done}, 64'd1);
    pend = resetn && rx_valid && rx_ready && drv_is_data;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"}, 64'({rx_ready, mem_we, core_resetn, busy, done, error}), 64'd0);
    chk({tag, "_waddr"}, 64'(mem_waddr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // Entry/exit at posedge+1.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic is_data);
    bit ok = 0;
    rx_data = b;
    rx_valid = 1'b1;
    drv_is_data = is_data;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    drv_is_data = 1'b0;
    if (!ok) chk("rx_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic load_image(input int n, input int gmin, input int gmax, input bit fixed);
    logic [7:0] b;
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", 64'({busy, rx_ready, done, error}), 64'b1100);
    @(posedge clk); #1;
    send_byte(8'(n), 1'b0);
    for (int i = 0; i < 4 * n; i++) begin
      repeat ($urandom_range(gmax, gmin)) @(posedge clk);
      #0;
      b = fixed ? basic_img[i] : 8'($urandom);
      exp_q.push_back({ADDR_W'(i), b});
      send_byte(b, 1'b1);
    end
    @(negedge clk);
    chk("first_done_cycle", 64'({done, core_resetn, busy}), 64'b100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("core_release", 64'({done, core_resetn}), 64'b11);
    chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       start;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [3:0] exp_rbde;
    logic       exp_core;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'h02, 4'b0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 4'b1100, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 4'b1100, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h11, 4'b0001, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h01, 4'b0001, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 4'b1100, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 4'b0010, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 4'b0010, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 8'h01, 4'b0010, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 4'b1100, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 4'b0010, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 4'b0010, 1'b1};

    // Reset with a byte offered and no start.
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_reset_outputs("reset");
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);

    // Control table: idle ignores bytes, oversize header, N==0, reload.
    for (int i = 0; i < 12; i++) begin
      start    = vecs[i].start;
      rx_valid = vecs[i].rx_valid;
      rx_data  = vecs[i].rx_data;
      @(posedge clk); #1;
      start    = 1'b0;
      rx_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_status", i), 64'({rx_ready, busy, done, error}), 64'(vecs[i].exp_rbde));
      chk($sformatf("vec%0d_core", i), {63'd0, core_resetn}, {63'd0, vecs[i].exp_core});
    end
    @(posedge clk); #1;

    // Basic back-to-back image, then gapped single word.
    load_image(2, 0, 0, 1'b1);
    load_image(1, 3, 3, 1'b0);

    // Full capacity, then bytes offered in DONE must be refused.
    load_image(16, 0, 0, 1'b0);
    rx_valid = 1'b1;
    drv_is_data = 1'b1;
    rx_data = 8'hEE;
    repeat (4) begin
      @(negedge clk);
      chk("no_accept_in_done", {63'd0, rx_ready}, 64'd0);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    drv_is_data = 1'b0;

    // Random images with random gaps.
    repeat (6) load_image($urandom_range(16, 1), 0, 3, 1'b0);

    // Reset mid-load after 3 of 8 bytes.
    pulse_start();
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({ADDR_W'(i), 8'(8'hA0 + i)});
      send_byte(8'(8'hA0 + i), 1'b1);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midload_reset");
    chk("midload_writes_seen", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Reload from DONE re-resets the core at the start edge.
    load_image(1, 0, 1, 1'b0);
    pulse_start();
    @(negedge clk);
    chk("reload_core_reset", 64'({core_resetn, busy, done}), 64'b010);
    @(posedge clk); #1;
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    chk("reload_n0_done", 64'({done, core_resetn}), 64'b10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reload_n0_release", 64'({done, core_resetn}), 64'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
